ballot_gate: RTL and testbench

Per-voter ballot gate between the button debouncers and the vote counter. Accepts a poll-officer arm pulse, then admits exactly one candidate selection as a single-cycle vote strobe. Rejects simultaneous multi-candidate presses and enforces release plus a lockout before the next voter can be armed. Keeps a saturating count of accepted ballots for cross-checking against the counter totals.

---
 rtl/ballot_gate_if.sv | 44 ++++
 rtl/ballot_gate.sv | 187 ++++++++++++++++++
 tb/tb_ballot_gate.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ballot_gate_if.sv
// ballot_gate_if
//   Groups the voter-facing signals of the ballot gate into one bundle.
//   master : the side that drives the buttons, officer arm and mode
//            (debouncers / control panel) and observes the gate results.
//   slave  : the ballot gate itself.
//   Signals:
//     mode              0 = voting, 1 = result display
//     arm               poll-officer arm request
//     cand1Val..4Val    debounced candidate button levels
//     vote1..vote4      one-cycle accepted-vote strobes
//     valid_vote_casted one-cycle pulse alongside any voteN strobe
//     armed             high while the gate waits for a selection
//     err_multi         one-cycle pulse on a rejected multi-press
//     timeout           one-cycle pulse when an armed voter times out
//     total_ballots     saturating count of accepted ballots
interface ballot_gate_if;
    logic       mode;
    logic       arm;
    logic       cand1Val;
    logic       cand2Val;
    logic       cand3Val;
    logic       cand4Val;
    logic       vote1;
    logic       vote2;
    logic       vote3;
    logic       vote4;
    logic       valid_vote_casted;
    logic       armed;
    logic       err_multi;
    logic       timeout;
    logic [9:0] total_ballots;

    modport master (
        output mode, arm, cand1Val, cand2Val, cand3Val, cand4Val,
        input  vote1, vote2, vote3, vote4, valid_vote_casted,
               armed, err_multi, timeout, total_ballots
    );

    modport slave (
        input  mode, arm, cand1Val, cand2Val, cand3Val, cand4Val,
        output vote1, vote2, vote3, vote4, valid_vote_casted,
               armed, err_multi, timeout, total_ballots
    );
endinterface

// File: rtl/ballot_gate.sv
// ballot_gate
//   Per-voter ballot gate between the button debouncers and the vote
//   counter. An officer arm admits exactly one candidate selection, which
//   is forwarded as a single-cycle vote strobe. Multi-candidate presses are
//   rejected, and the voter must release every button and sit out a
//   lockout before the next voter can be armed. A saturating count of
//   accepted ballots is kept for cross-checking the counter totals.
//
//   Ports:
//     clk  system clock, all logic on the rising edge
//     rst  synchronous active-high reset
//     bus  ballot_gate_if.slave (buttons, arm, mode in; strobes, status out)
//
//   Parameters:
//     LOCKOUT_CYCLES  cycles spent in LOCKOUT after release (>= 1)
//     TIMEOUT_CYCLES  cycles ARMED may wait for a selection (>= 1),
//                     only meaningful with BALLOT_TIMEOUT_EN
//
//   Build option:
//     BALLOT_TIMEOUT_EN  when defined, an armed voter who presses nothing
//                        for TIMEOUT_CYCLES cycles is dropped back to IDLE
//                        with a timeout pulse; otherwise ARMED waits
//                        indefinitely and timeout is held at 0.
module ballot_gate #(
    parameter int LOCKOUT_CYCLES = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input logic         clk,
    input logic         rst,
    ballot_gate_if.slave bus
);

    if (LOCKOUT_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("ballot_gate: LOCKOUT_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        WAIT_RELEASE,
        LOCKOUT
    } state_t;

    localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

    state_t            state;
    logic [3:0]        prev;
    logic [3:0]        vote_q;
    logic              valid_q;
    logic              armed_q;
    logic              err_q;
    logic [9:0]        total_q;
    logic [LOCK_W-1:0] lock_cnt;

`ifdef BALLOT_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt;
    logic            to_q;
`endif

    logic [3:0] cands;
    logic [3:0] rise;
    logic       any_high;
    logic       many_high;
    logic       single_rise;
    logic       multi_rise;

    // A valid ballot is one level high and that level just rose; any rise
    // while two or more levels are high is a rejected multi-press.
    // x & (x-1) clears the lowest set bit, so it is nonzero only when at
    // least two buttons are held.
    assign cands       = {bus.cand4Val, bus.cand3Val, bus.cand2Val, bus.cand1Val};
    assign rise        = cands & ~prev;
    assign any_high    = |cands;
    assign many_high   = |(cands & (cands - 4'd1));
    assign single_rise = (|rise) && !many_high;
    assign multi_rise  = (|rise) && many_high;

    // Gate state machine. All outputs are registered here; strobes default
    // to 0 every cycle so each one lasts exactly one cycle. mode = 1 forces
    // IDLE and clears the counters but leaves total_ballots alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            prev     <= 4'b0000;
            vote_q   <= 4'b0000;
            valid_q  <= 1'b0;
            armed_q  <= 1'b0;
            err_q    <= 1'b0;
            total_q  <= 10'd0;
            lock_cnt <= '0;
`ifdef BALLOT_TIMEOUT_EN
            to_cnt   <= '0;
            to_q     <= 1'b0;
`endif
        end else begin
            prev    <= cands;
            vote_q  <= 4'b0000;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
            to_q    <= 1'b0;
`endif
            if (bus.mode) begin
                state    <= IDLE;
                armed_q  <= 1'b0;
                lock_cnt <= '0;
`ifdef BALLOT_TIMEOUT_EN
                to_cnt   <= '0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.arm && !any_high) begin
                            state   <= ARMED;
                            armed_q <= 1'b1;
`ifdef BALLOT_TIMEOUT_EN
                            to_cnt  <= TO_LOAD;
`endif
                        end
                    end
                    ARMED: begin
                        if (single_rise) begin
                            vote_q  <= rise;
                            valid_q <= 1'b1;
                            if (total_q != 10'h3FF) begin
                                total_q <= total_q + 10'd1;
                            end
                            state   <= WAIT_RELEASE;
                            armed_q <= 1'b0;
                        end else if (multi_rise) begin
                            err_q   <= 1'b1;
                            state   <= WAIT_RELEASE;
                            armed_q <= 1'b0;
                        end
`ifdef BALLOT_TIMEOUT_EN
                        // A vote or reject in the expiry cycle wins over
                        // the timeout because it is checked first.
                        else if (to_cnt == '0) begin
                            to_q    <= 1'b1;
                            state   <= IDLE;
                            armed_q <= 1'b0;
                        end else begin
                            to_cnt <= to_cnt - 1'b1;
                        end
`endif
                    end
                    WAIT_RELEASE: begin
                        if (!any_high) begin
                            lock_cnt <= LOCK_LOAD;
                            state    <= LOCKOUT;
                        end
                    end
                    LOCKOUT: begin
                        if (lock_cnt == '0) begin
                            state <= IDLE;
                        end else begin
                            lock_cnt <= lock_cnt - 1'b1;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        armed_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.vote1             = vote_q[0];
    assign bus.vote2             = vote_q[1];
    assign bus.vote3             = vote_q[2];
    assign bus.vote4             = vote_q[3];
    assign bus.valid_vote_casted = valid_q;
    assign bus.armed             = armed_q;
    assign bus.err_multi         = err_q;
    assign bus.total_ballots     = total_q;
`ifdef BALLOT_TIMEOUT_EN
    assign bus.timeout           = to_q;
`else
    assign bus.timeout           = 1'b0;
`endif

endmodule

// File: tb/tb_ballot_gate.sv
// tb_ballot_gate
//   Bench for ballot_gate. Directed stimulus pushes the expected strobe
//   events (vote / reject / timeout with the running ballot total) into a
//   queue; a monitor on the falling edge pops one entry whenever the gate
//   presents any strobe and compares it. Level outputs such as armed and
//   total_ballots are checked directly after selected cycles.
module tb_ballot_gate;

    localparam int LOCK = 4;
    localparam int TOUT = 5;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ballot_gate_if bus ();

    ballot_gate #(
        .LOCKOUT_CYCLES(LOCK),
        .TIMEOUT_CYCLES(TOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct packed {
        logic [3:0] vote;
        logic       valid;
        logic       err;
        logic       to;
        logic [9:0] total;
    } ev_t;

    ev_t expQ[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  expTotal   = 0;

    function automatic ev_t sampleEv();
        ev_t e;
        e.vote  = {bus.vote4, bus.vote3, bus.vote2, bus.vote1};
        e.valid = bus.valid_vote_casted;
        e.err   = bus.err_multi;
        e.to    = bus.timeout;
        e.total = bus.total_ballots;
        return e;
    endfunction

    // Scoreboard monitor: any strobe must match the oldest expected event.
    always @(negedge clk) begin
        ev_t got;
        ev_t exp_e;
        got = sampleEv();
        if (got.vote != 4'b0000 || got.valid || got.err || got.to) begin
            compared++;
            if (expQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL spurious_event got=%h expected=none at %0t", got, $time);
            end else begin
                exp_e = expQ.pop_front();
                if (got !== exp_e) begin
                    mismatched++;
                    $display("[TB] FAIL strobe_event got=%h expected=%h at %0t", got, exp_e, $time);
                end
            end
        end
    end

    task automatic applyStimulus(input logic a, input logic m, input logic [3:0] c);
        bus.arm  = a;
        bus.mode = m;
        {bus.cand4Val, bus.cand3Val, bus.cand2Val, bus.cand1Val} = c;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp_v);
        compared++;
        if (got !== exp_v) begin
            mismatched++;
            $display("[TB] FAIL %s got=%0h expected=%0h at %0t", name, got, exp_v, $time);
        end
    endtask

    task automatic expectVote(input logic [3:0] c);
        if (expTotal < 1023) expTotal++;
        expQ.push_back({c, 1'b1, 1'b0, 1'b0, 10'(expTotal)});
    endtask

    task automatic expectErr();
        expQ.push_back({4'b0000, 1'b0, 1'b1, 1'b0, 10'(expTotal)});
    endtask

    task automatic expectTimeout();
        expQ.push_back({4'b0000, 1'b0, 1'b0, 1'b1, 10'(expTotal)});
    endtask

    // Release all buttons, then spend the lockout; optionally hammer arm
    // during lockout and require that it is ignored. Leaves the gate in IDLE.
    task automatic releaseWithLockout(input bit probeArm);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        for (int i = 0; i < LOCK; i++) begin
            applyStimulus(probeArm, 1'b0, 4'b0000);
            if (probeArm) checkOutput("armed_in_lockout", 32'(bus.armed), 32'd0);
        end
    endtask

    function automatic logic [31:0] allOutputs();
        return 32'({bus.vote4, bus.vote3, bus.vote2, bus.vote1, bus.valid_vote_casted,
                    bus.armed, bus.err_multi, bus.timeout, bus.total_ballots});
    endfunction

    initial begin
        logic [3:0] c;
        rst      = 1'b1;
        bus.arm  = 1'b0;
        bus.mode = 1'b0;
        {bus.cand4Val, bus.cand3Val, bus.cand2Val, bus.cand1Val} = 4'b0000;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outputs", allOutputs(), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b0000);

        // Single clean vote for candidate 3.
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("arm_latency", 32'(bus.armed), 32'd1);
        expectVote(4'b0100);
        applyStimulus(1'b0, 1'b0, 4'b0100);
        checkOutput("armed_after_vote", 32'(bus.armed), 32'd0);
        checkOutput("total_after_vote", 32'(bus.total_ballots), 32'(expTotal));
        applyStimulus(1'b0, 1'b0, 4'b0100);
        checkOutput("vote3_one_cycle", 32'(bus.vote3), 32'd0);
        releaseWithLockout(1'b1);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("arm_after_lockout", 32'(bus.armed), 32'd1);

        // Multi-press reject.
        expectErr();
        applyStimulus(1'b0, 1'b0, 4'b0011);
        checkOutput("armed_after_multi", 32'(bus.armed), 32'd0);
        checkOutput("total_after_multi", 32'(bus.total_ballots), 32'(expTotal));
        releaseWithLockout(1'b1);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("rearm_after_multi", 32'(bus.armed), 32'd1);

        // Vote for candidate 2, then hold it while the officer keeps arming.
        expectVote(4'b0010);
        applyStimulus(1'b0, 1'b0, 4'b0010);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i[0] ? 1'b0 : 1'b1, 1'b0, 4'b0010);
            checkOutput("arm_while_held", 32'(bus.armed), 32'd0);
        end
        releaseWithLockout(1'b1);

        // Arm in IDLE with a button held is refused.
        applyStimulus(1'b1, 1'b0, 4'b0001);
        checkOutput("arm_with_button_held", 32'(bus.armed), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'b0000);

        // Arm together with mode = 1: mode wins.
        applyStimulus(1'b1, 1'b1, 4'b0000);
        checkOutput("arm_vs_mode", 32'(bus.armed), 32'd0);

        // Mode raised in the same cycle cand4 rises: no vote.
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("arm_before_mode", 32'(bus.armed), 32'd1);
        applyStimulus(1'b0, 1'b1, 4'b1000);
        checkOutput("armed_after_mode", 32'(bus.armed), 32'd0);
        checkOutput("total_held_on_mode", 32'(bus.total_ballots), 32'(expTotal));
        applyStimulus(1'b0, 1'b0, 4'b1000);
        checkOutput("idle_after_mode", 32'(bus.armed), 32'd0);
        applyStimulus(1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("arm_after_mode", 32'(bus.armed), 32'd1);

        // Armed with no selection.
`ifdef BALLOT_TIMEOUT_EN
        for (int i = 0; i < TOUT - 1; i++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000);
            checkOutput("armed_before_timeout", 32'(bus.armed), 32'd1);
        end
        expectTimeout();
        applyStimulus(1'b0, 1'b0, 4'b0000);
        checkOutput("armed_after_timeout", 32'(bus.armed), 32'd0);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("arm_after_timeout", 32'(bus.armed), 32'd1);
`else
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 4'b0000);
        end
        checkOutput("armed_waits", 32'(bus.armed), 32'd1);
        checkOutput("timeout_tied_low", 32'(bus.timeout), 32'd0);
`endif
        expectVote(4'b0001);
        applyStimulus(1'b0, 1'b0, 4'b0001);
        releaseWithLockout(1'b0);

        // Saturation of total_ballots.
        for (int i = 0; i < 1030; i++) begin
            applyStimulus(1'b1, 1'b0, 4'b0000);
            c = 4'b0001 << (i % 4);
            expectVote(c);
            applyStimulus(1'b0, 1'b0, c);
            releaseWithLockout(1'b0);
        end
        checkOutput("total_saturated", 32'(bus.total_ballots), 32'd1023);

        // Reset while in WAIT_RELEASE.
        applyStimulus(1'b1, 1'b0, 4'b0000);
        expectVote(4'b0100);
        applyStimulus(1'b0, 1'b0, 4'b0100);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'b0100);
        checkOutput("reset_in_wait_release", allOutputs(), 32'd0);
        expTotal = 0;
        rst = 1'b0;

        // Reset overrides a strobe that would issue the same cycle.
        applyStimulus(1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'b1000);
        checkOutput("reset_beats_vote", allOutputs(), 32'd0);
        rst = 1'b0;

        // Counting restarts from zero after reset.
        applyStimulus(1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        expectVote(4'b0001);
        applyStimulus(1'b0, 1'b0, 4'b0001);
        checkOutput("total_after_reset", 32'(bus.total_ballots), 32'(expTotal));
        applyStimulus(1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 4'b0000);

        checkOutput("scoreboard_drained", 32'(expQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
